// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer feeding the prefetch buffer and decoder
module fetch_controller #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BUF_HALFWORDS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic        instr_mem_req,
  output logic [31:0] instr_mem_addr,
  input  logic        instr_mem_gnt,
  input  logic        instr_mem_rvalid,
  input  logic [31:0] instr_mem_rdata,
  output logic        buf_write_en,
  output logic [31:0] buf_data_in,
  output logic [1:0]  buf_read_en,
  output logic        buf_flush,
  input  logic [31:0] buf_data_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_rdata,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ALIGN = 2'd2;

  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);
  localparam logic [4:0] BUF_HW  = 5'(BUF_HALFWORDS);

  logic [1:0]  state_q, state_d;
  logic [3:0]  occ_q, occ_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  discard_q, discard_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;

  logic        accept;
  logic        keep;
  logic        consume;
  logic        align_drop;
  logic        room;
  logic [4:0]  demand;
  logic [1:0]  hw_used;

  assign instr_compressed = buf_data_out[1:0] != 2'b11;

  // Reserve buffer space for every in-flight word, including ones that will be discarded.
  assign demand = {1'b0, occ_q} + {2'b00, outst_q, 1'b0} + 5'd2;
  assign room   = demand <= BUF_HW;

  assign instr_mem_req  = fetch_en && (state_q != S_IDLE) && !jump_en
                          && (outst_q < MAX_OUT) && room;
  assign instr_mem_addr = addr_q;
  assign accept         = instr_mem_req && instr_mem_gnt;

  assign keep         = instr_mem_rvalid && (discard_q == 2'd0);
  assign buf_write_en = keep && !jump_en;
  assign buf_data_in  = instr_mem_rdata;
  assign buf_flush    = jump_en;

  assign instr_valid = (state_q == S_FETCH) && !jump_en
                       && ((occ_q >= 4'd2) || ((occ_q == 4'd1) && instr_compressed));
  assign instr_rdata = buf_data_out;
  assign instr_pc    = pc_q;
  assign consume     = instr_valid && instr_ready;

  // A halfword-aligned target drops the low half of the first word it lands in.
  assign align_drop = buf_write_en && (state_q == S_ALIGN);

  always_comb begin
    buf_read_en = 2'b00;
    if (align_drop) begin
      buf_read_en = 2'b10;
    end else if (consume) begin
      buf_read_en = instr_compressed ? 2'b10 : 2'b11;
    end
  end

  always_comb begin
    hw_used = 2'd0;
    if (buf_read_en == 2'b10) begin
      hw_used = 2'd1;
    end else if (buf_read_en == 2'b11) begin
      hw_used = 2'd2;
    end
  end

  always_comb begin
    state_d   = state_q;
    outst_d   = outst_q + {1'b0, accept} - {1'b0, instr_mem_rvalid};
    occ_d     = occ_q + (buf_write_en ? 4'd2 : 4'd0) - {2'b00, hw_used};
    pc_d      = consume ? pc_q + (instr_compressed ? 32'd2 : 32'd4) : pc_q;
    addr_d    = accept ? addr_q + 32'd4 : addr_q;
    discard_d = (instr_mem_rvalid && (discard_q != 2'd0)) ? discard_q - 2'd1 : discard_q;

    case (state_q)
      S_IDLE:  if (fetch_en) state_d = S_FETCH;
      S_ALIGN: if (buf_write_en) state_d = S_FETCH;
      default: state_d = state_q;
    endcase

    // Everything still in flight after this cycle belongs to the old stream.
    if (jump_en) begin
      state_d   = jump_target[1] ? S_ALIGN : S_FETCH;
      occ_d     = 4'd0;
      pc_d      = jump_target & ~32'd1;
      addr_d    = jump_target & ~32'd3;
      discard_d = outst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      occ_q     <= 4'd0;
      outst_q   <= 2'd0;
      discard_q <= 2'd0;
      addr_q    <= RESET_PC & ~32'd3;
      pc_q      <= RESET_PC & ~32'd1;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed bench for fetch_controller with buffer and memory models
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        instr_mem_req;
  logic [31:0] instr_mem_addr;
  logic        instr_mem_gnt;
  logic        instr_mem_rvalid;
  logic [31:0] instr_mem_rdata;
  logic        buf_write_en;
  logic [31:0] buf_data_in;
  logic [1:0]  buf_read_en;
  logic        buf_flush;
  logic [31:0] buf_data_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  fetch_controller #(
    .RESET_PC(32'h0000_0000),
    .MAX_OUTSTANDING(2),
    .BUF_HALFWORDS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .jump_en(jump_en),
    .jump_target(jump_target),
    .instr_mem_req(instr_mem_req),
    .instr_mem_addr(instr_mem_addr),
    .instr_mem_gnt(instr_mem_gnt),
    .instr_mem_rvalid(instr_mem_rvalid),
    .instr_mem_rdata(instr_mem_rdata),
    .buf_write_en(buf_write_en),
    .buf_data_in(buf_data_in),
    .buf_read_en(buf_read_en),
    .buf_flush(buf_flush),
    .buf_data_out(buf_data_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_rdata(instr_rdata),
    .instr_pc(instr_pc),
    .instr_compressed(instr_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Prefetch buffer: 4 words, halfword read pointer.
  logic [15:0] bmem [8];
  logic [2:0]  brd;
  logic [1:0]  bwr;
  int          bcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brd  <= 3'd0;
      bwr  <= 2'd0;
      bcnt <= 0;
      for (int i = 0; i < 8; i++) bmem[i] <= 16'h0;
    end else if (buf_flush) begin
      brd  <= 3'd0;
      bwr  <= 2'd0;
      bcnt <= 0;
    end else begin
      if (buf_write_en) begin
        bmem[{bwr, 1'b0}] <= buf_data_in[15:0];
        bmem[{bwr, 1'b1}] <= buf_data_in[31:16];
        bwr <= bwr + 2'd1;
      end
      if (buf_read_en == 2'b10) brd <= brd + 3'd1;
      else if (buf_read_en == 2'b11) brd <= brd + 3'd2;
      bcnt <= bcnt + (buf_write_en ? 2 : 0)
              - ((buf_read_en == 2'b10) ? 1 : ((buf_read_en == 2'b11) ? 2 : 0));
    end
  end

  assign buf_data_out = {bmem[brd + 3'd1], bmem[brd]};

  // Memory: in-order responses a selectable 1..3 cycles after grant.
  logic [31:0] mem [0:127];
  logic [2:0]  pv;
  logic [31:0] pa [3];
  logic [1:0]  lat_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= 3'b000;
    else        pv <= {pv[1:0], instr_mem_req & instr_mem_gnt};
  end

  always @(posedge clk) begin
    pa[0] <= instr_mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
  end

  assign instr_mem_rvalid = pv[lat_sel];
  assign instr_mem_rdata  = mem[pa[lat_sel][8:2]];

  int          wr_count, gnt_count, out_tb, max_out, max_bcnt, disc;
  logic        after_flush, got_wr, got_gnt;
  logic [31:0] first_wr_data, first_gnt_addr;
  logic [1:0]  first_wr_ren;
  logic [31:0] dq_pc[$];
  logic [31:0] dq_data[$];
  logic [31:0] dq_ren[$];

  function automatic logic [31:0] dget(input int which, input int i);
    if (i >= dq_pc.size()) return 32'hDEAD_BEEF;
    case (which)
      0:       return dq_pc[i];
      1:       return dq_data[i];
      default: return dq_ren[i];
    endcase
  endfunction

  task automatic clear_mon();
    wr_count = 0; gnt_count = 0; out_tb = 0; max_out = 0; max_bcnt = 0; disc = 0;
    after_flush = 1'b0; got_wr = 1'b0; got_gnt = 1'b0;
    first_wr_data = '0; first_gnt_addr = '0; first_wr_ren = '0;
    dq_pc.delete(); dq_data.delete(); dq_ren.delete();
  endtask

  // Observe one cycle at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (buf_flush) begin
        after_flush = 1'b1; disc = 0; got_wr = 1'b0; got_gnt = 1'b0;
        dq_pc.delete(); dq_data.delete(); dq_ren.delete();
      end else begin
        if (after_flush && instr_mem_rvalid && !buf_write_en) disc++;
        if (buf_write_en) begin
          wr_count++;
          if (!got_wr) begin
            got_wr = 1'b1; first_wr_data = buf_data_in; first_wr_ren = buf_read_en;
          end
        end
        if (instr_mem_req && instr_mem_gnt && !got_gnt) begin
          got_gnt = 1'b1; first_gnt_addr = instr_mem_addr;
        end
        if (instr_valid && instr_ready) begin
          dq_pc.push_back(instr_pc);
          dq_data.push_back(instr_rdata);
          dq_ren.push_back({30'b0, buf_read_en});
        end
      end
      if (instr_mem_req && instr_mem_gnt) gnt_count++;
      out_tb = out_tb + ((instr_mem_req && instr_mem_gnt) ? 1 : 0) - (instr_mem_rvalid ? 1 : 0);
      if (out_tb > max_out) max_out = out_tb;
      if (bcnt > max_bcnt) max_bcnt = bcnt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic [1:0] lat);
    rst_n = 1'b0;
    fetch_en = 1'b0; jump_en = 1'b0; jump_target = '0;
    instr_mem_gnt = 1'b0; instr_ready = 1'b0;
    lat_sel = lat;
    run(2);
    clear_mon();
    rst_n = 1'b1;
  endtask

  task automatic mem_fill();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mem_fill();
    clear_mon();
    rst_n = 1'b0;
    fetch_en = 1'b0; jump_en = 1'b0; jump_target = '0;
    instr_mem_gnt = 1'b0; instr_ready = 1'b0; lat_sel = 2'd0;
    #1;

    // T0: reset state
    chk("rst_req", {31'b0, instr_mem_req}, 32'd0);
    chk("rst_addr", instr_mem_addr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_strobes", {28'b0, buf_write_en, buf_read_en, buf_flush}, 32'd0);

    // T1: straight-line 32-bit stream
    do_reset(2'd0);
    fetch_en = 1'b1; instr_mem_gnt = 1'b1; instr_ready = 1'b1;
    run(24);
    chk("t1_ndeliv", {31'b0, dq_pc.size() >= 8}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc", dget(0, i), 32'(4 * i));
      chk("t1_rdata", dget(1, i), 32'h0000_0013);
      chk("t1_ren", dget(2, i), 32'd3);
    end
    chk("t1_first_addr", first_gnt_addr, 32'h0);
    chk("t1_max_out", {31'b0, max_out <= 2}, 32'd1);

    // T2: mixed compressed / 32-bit
    mem[0] = 32'h0013_0001;
    mem[1] = 32'h0001_0000;
    do_reset(2'd0);
    fetch_en = 1'b1; instr_mem_gnt = 1'b1; instr_ready = 1'b1;
    run(16);
    chk("t2_pc0", dget(0, 0), 32'h0);
    chk("t2_ren0", dget(2, 0), 32'd2);
    chk("t2_lo0", dget(1, 0) & 32'hFFFF, 32'h0001);
    chk("t2_pc1", dget(0, 1), 32'h2);
    chk("t2_rd1", dget(1, 1), 32'h0000_0013);
    chk("t2_ren1", dget(2, 1), 32'd3);
    chk("t2_pc2", dget(0, 2), 32'h6);
    chk("t2_lo2", dget(1, 2) & 32'hFFFF, 32'h0001);
    chk("t2_ren2", dget(2, 2), 32'd2);
    chk("t2_pc3", dget(0, 3), 32'h8);
    chk("t2_rd3", dget(1, 3), 32'h0000_0013);
    mem_fill();

    // T3: decoder stalled fills the buffer exactly
    do_reset(2'd0);
    fetch_en = 1'b1; instr_mem_gnt = 1'b1; instr_ready = 1'b0;
    run(20);
    chk("t3_writes", 32'(wr_count), 32'd4);
    chk("t3_grants", 32'(gnt_count), 32'd4);
    chk("t3_max_occ", 32'(max_bcnt), 32'd8);
    chk("t3_req_off", {31'b0, instr_mem_req}, 32'd0);
    chk("t3_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    run(10);
    chk("t3_resume", {31'b0, gnt_count > 4}, 32'd1);

    // T4: jump to halfword target with two requests in flight
    mem[64] = 32'hAAAA_0001;
    mem[65] = 32'h0000_0013;
    do_reset(2'd2);
    fetch_en = 1'b1; instr_mem_gnt = 1'b1; instr_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!(out_tb == 2 && !instr_mem_rvalid) && k < 20) begin
        tick();
        k++;
      end
      chk("t4_setup_timeout", {31'b0, k < 20}, 32'd1);
    end
    jump_en = 1'b1; jump_target = 32'h0000_0102;
    #1;
    chk("t4_flush", {31'b0, buf_flush}, 32'd1);
    chk("t4_req_blk", {31'b0, instr_mem_req}, 32'd0);
    chk("t4_valid_blk", {31'b0, instr_valid}, 32'd0);
    tick();
    jump_en = 1'b0;
    run(16);
    chk("t4_discarded", 32'(disc), 32'd2);
    chk("t4_new_addr", first_gnt_addr, 32'h0000_0100);
    chk("t4_first_wr", first_wr_data, 32'hAAAA_0001);
    chk("t4_align_ren", {30'b0, first_wr_ren}, 32'd2);
    chk("t4_pc0", dget(0, 0), 32'h0000_0102);
    chk("t4_lo0", dget(1, 0) & 32'hFFFF, 32'h0000_AAAA);
    chk("t4_pc1", dget(0, 1), 32'h0000_0104);
    chk("t4_ren1", dget(2, 1), 32'd3);

    // T5: jump coincident with a response and a grant
    mem[16] = 32'h1234_5677;
    mem[17] = 32'h0000_0013;
    do_reset(2'd0);
    fetch_en = 1'b1; instr_mem_gnt = 1'b1; instr_ready = 1'b1;
    run(6);
    begin
      int k;
      k = 0;
      while (!(instr_mem_rvalid && out_tb == 1) && k < 20) begin
        tick();
        k++;
      end
      chk("t5_setup_timeout", {31'b0, k < 20}, 32'd1);
    end
    jump_en = 1'b1; jump_target = 32'h0000_0040;
    #1;
    chk("t5_no_write", {31'b0, buf_write_en}, 32'd0);
    chk("t5_req_blk", {31'b0, instr_mem_req}, 32'd0);
    tick();
    jump_en = 1'b0;
    run(10);
    chk("t5_discarded", 32'(disc), 32'd0);
    chk("t5_new_addr", first_gnt_addr, 32'h0000_0040);
    chk("t5_first_wr", first_wr_data, 32'h1234_5677);
    chk("t5_pc0", dget(0, 0), 32'h0000_0040);
    chk("t5_rd0", dget(1, 0), 32'h1234_5677);
    mem_fill();

    // T6: asynchronous reset mid-burst, then restart
    do_reset(2'd0);
    fetch_en = 1'b1; instr_mem_gnt = 1'b1; instr_ready = 1'b1;
    run(7);
    rst_n = 1'b0;
    #1;
    chk("t6_req", {31'b0, instr_mem_req}, 32'd0);
    chk("t6_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_strobes", {28'b0, buf_write_en, buf_read_en, buf_flush}, 32'd0);
    chk("t6_addr", instr_mem_addr, 32'h0);
    chk("t6_pc", instr_pc, 32'h0);
    run(2);
    clear_mon();
    rst_n = 1'b1;
    run(10);
    chk("t6_restart_addr", first_gnt_addr, 32'h0);
    chk("t6_restart_pc", dget(0, 0), 32'h0);
    chk("t6_restart_pc1", dget(0, 1), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
